// File: rtl/mul_ser_rr_arb.sv
// Round-robin scheduler sharing one serial shift-add signed multiplier
// between N requesters; returns the 2W-bit product with a one-hot done strobe.
module mul_ser_rr_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   x_bus,
  input  logic [N*W-1:0]   a_bus,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [2*W-1:0]   y,
  output logic             busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned PRW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [PW-1:0]  ptr, ptr_n;
  logic [PW-1:0]  owner, owner_n;
  logic [PRW-1:0] t, t_n;
  logic [PRW-1:0] p, p_n;
  logic [W-1:0]   a_reg, a_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [PRW-1:0] y_n;
  logic [N-1:0]   gnt_n, done_n;
  logic           busy_n;

  logic           found;
  logic [PW-1:0]  win;
  logic [PW-1:0]  idx;
  int unsigned    sum;
  logic [W-1:0]   x_sel, a_sel;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      t     <= '0;
      p     <= '0;
      a_reg <= '0;
      cnt   <= '0;
      y     <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      t     <= t_n;
      p     <= p_n;
      a_reg <= a_n;
      cnt   <= cnt_n;
      y     <= y_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

  // Next-state, arbitration and shift-add iteration
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    t_n     = t;
    p_n     = p;
    a_n     = a_reg;
    cnt_n   = cnt;
    y_n     = y;
    gnt_n   = '0;
    done_n  = '0;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    sum     = 0;

    // Scan ptr, ptr+1, ... (mod N) for the first active request
    for (int unsigned i = 0; i < N; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    x_sel = x_bus[int'(win)*W +: W];
    a_sel = a_bus[int'(win)*W +: W];

    case (state)
      IDLE: begin
        if (found) begin
          gnt_n[win] = 1'b1;
          t_n        = {{W{x_sel[W-1]}}, x_sel};
          a_n        = a_sel;
          p_n        = '0;
          cnt_n      = '0;
          owner_n    = win;
          ptr_n      = (win == PW'(N - 1)) ? '0 : win + PW'(1);
          state_n    = MUL;
        end
      end
      MUL: begin
        // The last multiplier bit is the sign bit and carries weight -2^(W-1)
        if (a_reg[0]) begin
          p_n = (cnt == CW'(W - 1)) ? p - t : p + t;
        end
        a_n   = a_reg >> 1;
        t_n   = t << 1;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(W - 1)) state_n = DONE;
      end
      DONE: begin
        y_n           = p;
        done_n[owner] = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mul_ser_rr_arb.sv
// Randomized self-checking bench for mul_ser_rr_arb against a behavioural
// model of the round-robin pick and the signed product.
module tb_mul_ser_rr_arb;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   x_bus = '0;
  logic [N*W-1:0]   a_bus = '0;
  logic [N-1:0]     gnt, done;
  logic [2*W-1:0]   y;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  mul_ser_rr_arb #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .x_bus(x_bus), .a_bus(a_bus),
    .gnt(gnt), .done(done), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [2*W-1:0] model_mul(logic [W-1:0] xv, logic [W-1:0] av);
    int xi, ai, pr;
    xi = int'($signed(xv));
    ai = int'($signed(av));
    pr = xi * ai;
    return pr[2*W-1:0];
  endfunction

  task automatic set_ops(int i, logic [W-1:0] xv, logic [W-1:0] av);
    x_bus[i*W +: W] = xv;
    a_bus[i*W +: W] = av;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (gnt == '0 && cyc < 50);
    g = gnt;
  endtask

  task automatic wait_done(output logic [N-1:0] d, output logic [2*W-1:0] yy,
                           output logic b, output int cyc, output logic [N-1:0] gseen);
    cyc = 0;
    gseen = '0;
    do begin tick(); cyc++; gseen |= gnt; end while (done == '0 && cyc < 50);
    d = done;
    yy = y;
    b = busy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if ({gnt, done, y, busy} !== '0) begin errors++;
      $display("FAIL reset_hold gnt=%b done=%b y=%h busy=%b exp all 0", gnt, done, y, busy); end
    reset = 1'b0;
    model_ptr = 0;
    tick();
    checks++; if ({gnt, done, y, busy} !== '0) begin errors++;
      $display("FAIL reset_idle gnt=%b done=%b y=%h busy=%b exp all 0", gnt, done, y, busy); end
  endtask

  task automatic test_single();
    logic [N-1:0] g, d, gs; logic [2*W-1:0] yy; logic b; int c;
    do_reset();
    set_ops(0, 8'd5, 8'hFD);
    req = 4'b0001;
    wait_gnt(g, c);
    req[0] = 1'b0;
    checks++; if (g !== 4'b0001 || c !== 1) begin errors++;
      $display("FAIL single_gnt got=%b after %0d exp=0001 after 1", g, c); end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL single_busy got=%b exp=1", busy); end
    wait_done(d, yy, b, c, gs);
    checks++; if (d !== 4'b0001 || c !== W + 1) begin errors++;
      $display("FAIL single_done got=%b after %0d exp=0001 after %0d", d, c, W + 1); end
    checks++; if (yy !== 16'hFFF1) begin errors++;
      $display("FAIL single_y got=%h exp=fff1", yy); end
    checks++; if (b !== 1'b0) begin errors++;
      $display("FAIL single_busy_done got=%b exp=0", b); end
    tick();
    checks++; if (done !== '0 || gnt !== '0 || busy !== 1'b0 || y !== 16'hFFF1) begin errors++;
      $display("FAIL single_after done=%b gnt=%b busy=%b y=%h exp 0/0/0/fff1", done, gnt, busy, y); end
    model_ptr = 1;
  endtask

  task automatic test_corners();
    logic [W-1:0]   xs [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
    logic [W-1:0]   as [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
    logic [2*W-1:0] ys [4] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};
    logic [N-1:0] g, d, gs, m; logic [2*W-1:0] yy; logic b; int c, r;
    for (int k = 0; k < 4; k++) begin
      r = int'($urandom_range(0, N - 1));
      x_bus = {$urandom, $urandom};
      a_bus = {$urandom, $urandom};
      set_ops(r, xs[k], as[k]);
      m = '0; m[r] = 1'b1;
      req = m;
      wait_gnt(g, c);
      req = '0;
      checks++; if (g !== m) begin errors++;
        $display("FAIL corner%0d_gnt got=%b exp=%b", k, g, m); end
      wait_done(d, yy, b, c, gs);
      checks++; if (d !== m || yy !== ys[k] || c !== W + 1) begin errors++;
        $display("FAIL corner%0d got done=%b y=%h lat=%0d exp done=%b y=%h lat=%0d",
                 k, d, yy, c, m, ys[k], W + 1); end
      model_ptr = (r + 1) % N;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] g, d, gs, mask, e; logic [2*W-1:0] yy, ey; logic b; int c, w;
    logic [W-1:0] xv [N]; logic [W-1:0] av [N];
    for (int round = 0; round < 8; round++) begin
      for (int i = 0; i < N; i++) begin
        xv[i] = W'($urandom); av[i] = W'($urandom); set_ops(i, xv[i], av[i]);
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      req = mask;
      for (int k = 0; k < N && mask != '0; k++) begin
        w = model_pick(mask, model_ptr);
        e = '0; e[w] = 1'b1;
        ey = model_mul(xv[w], av[w]);
        wait_gnt(g, c);
        mask &= ~g;
        req = mask;
        set_ops(w, W'($urandom), W'($urandom));
        checks++; if (g !== e || c !== 1) begin errors++;
          $display("FAIL rand%0d_gnt got=%b after %0d exp=%b after 1", round, g, c, e); end
        wait_done(d, yy, b, c, gs);
        checks++; if (d !== e || yy !== ey || c !== W + 1) begin errors++;
          $display("FAIL rand%0d_done got done=%b y=%h lat=%0d exp done=%b y=%h lat=%0d",
                   round, d, yy, c, e, ey, W + 1); end
        model_ptr = (w + 1) % N;
      end
      req = '0;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] g, d, gs, mask, e; logic [2*W-1:0] yy, ey; logic b; int c, c2;
    logic [W-1:0] xv [N]; logic [W-1:0] av [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      xv[i] = W'($urandom); av[i] = W'($urandom); set_ops(i, xv[i], av[i]);
    end
    mask = '1;
    req = mask;
    for (int k = 0; k < N; k++) begin
      e = '0; e[k] = 1'b1;
      ey = model_mul(xv[k], av[k]);
      wait_gnt(g, c);
      mask &= ~g;
      req = mask;
      wait_done(d, yy, b, c2, gs);
      checks++; if (g !== e || d !== e || yy !== ey || c + c2 !== W + 2) begin errors++;
        $display("FAIL b2b%0d got gnt=%b done=%b y=%h spacing=%0d exp %b/%b/%h/%0d",
                 k, g, d, yy, c + c2, e, e, ey, W + 2); end
    end
    req = '0;
    model_ptr = 0;
  endtask

  task automatic test_rr_skip();
    logic [N-1:0] g, d, gs, mask, e, seen; logic [2*W-1:0] yy; logic b; int c;
    int order [3] = '{3, 0, 1};
    do_reset();
    x_bus = {$urandom, $urandom};
    a_bus = {$urandom, $urandom};
    req = 4'b0010;
    wait_gnt(g, c);
    req = '0;
    checks++; if (g !== 4'b0010) begin errors++;
      $display("FAIL skip_first got=%b exp=0010", g); end
    wait_done(d, yy, b, c, gs);
    mask = 4'b1011;
    req = mask;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      e = '0; e[order[k]] = 1'b1;
      wait_gnt(g, c);
      seen |= g;
      mask &= ~g;
      req = mask;
      checks++; if (g !== e) begin errors++;
        $display("FAIL skip%0d_gnt got=%b exp=%b", k, g, e); end
      wait_done(d, yy, b, c, gs);
      seen |= gs;
    end
    req = '0;
    checks++; if (seen[2] !== 1'b0) begin errors++;
      $display("FAIL skip_req2 got gnt2=%b exp=0", seen[2]); end
    model_ptr = 2;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g, d, gs, dany; logic [2*W-1:0] yy; logic b; int c;
    do_reset();
    set_ops(0, 8'd3, 8'd7);
    req = 4'b0001;
    wait_gnt(g, c);
    req = '0;
    wait_done(d, yy, b, c, gs);
    checks++; if (yy !== 16'd21) begin errors++;
      $display("FAIL mid_pre_y got=%h exp=0015", yy); end
    set_ops(0, 8'hFB, 8'd9);
    req = 4'b0001;
    wait_gnt(g, c);
    req = '0;
    for (int k = 0; k < 4; k++) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if ({gnt, done, y, busy} !== '0) begin errors++;
      $display("FAIL mid_async gnt=%b done=%b y=%h busy=%b exp all 0", gnt, done, y, busy); end
    tick();
    tick();
    reset = 1'b0;
    model_ptr = 0;
    dany = '0;
    for (int k = 0; k < W + 4; k++) begin tick(); dany |= done; end
    checks++; if (dany !== '0 || y !== '0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_no_done done=%b y=%h busy=%b exp 0/0/0", dany, y, busy); end
    set_ops(2, 8'hF9, 8'd6);
    req = 4'b0100;
    wait_gnt(g, c);
    req = '0;
    checks++; if (g !== N'(1 << model_pick(4'b0100, model_ptr)) || c !== 1) begin errors++;
      $display("FAIL mid_regrant got=%b after %0d exp=0100 after 1", g, c); end
    wait_done(d, yy, b, c, gs);
    checks++; if (d !== 4'b0100 || yy !== model_mul(8'hF9, 8'd6)) begin errors++;
      $display("FAIL mid_job got done=%b y=%h exp done=0100 y=%h", d, yy, model_mul(8'hF9, 8'd6)); end
    model_ptr = 3;
  endtask

  task automatic test_operand_change();
    logic [N-1:0] g, d, gs, er, eo; logic [2*W-1:0] yy, ey, ey2; logic b; int c, r, o;
    logic [W-1:0] xv, av, xo, ao;
    for (int rep = 0; rep < 3; rep++) begin
      r = int'($urandom_range(0, N - 1));
      o = (r + 2) % N;
      xv = W'($urandom); av = W'($urandom); xo = W'($urandom); ao = W'($urandom);
      set_ops(r, xv, av);
      set_ops(o, xo, ao);
      ey = model_mul(xv, av);
      ey2 = model_mul(xo, ao);
      er = '0; er[model_pick(N'(1 << r), model_ptr)] = 1'b1;
      eo = '0; eo[o] = 1'b1;
      req = N'(1 << r);
      wait_gnt(g, c);
      req = '0;
      checks++; if (g !== er) begin errors++;
        $display("FAIL opchg%0d_gnt got=%b exp=%b", rep, g, er); end
      model_ptr = (r + 1) % N;
      tick(); tick(); tick();
      set_ops(r, ~xv, av ^ 8'h5A);
      req[o] = 1'b1;
      wait_done(d, yy, b, c, gs);
      checks++; if (d !== er || yy !== ey || gs !== '0) begin errors++;
        $display("FAIL opchg%0d_done got done=%b y=%h gnt_during=%b exp %b/%h/0", rep, d, yy, gs, er, ey); end
      wait_gnt(g, c);
      req = '0;
      checks++; if (g !== eo || c !== 1) begin errors++;
        $display("FAIL opchg%0d_next got=%b after %0d exp=%b after 1", rep, g, c, eo); end
      model_ptr = (o + 1) % N;
      wait_done(d, yy, b, c, gs);
      checks++; if (d !== eo || yy !== ey2) begin errors++;
        $display("FAIL opchg%0d_next_done got done=%b y=%h exp %b/%h", rep, d, yy, eo, ey2); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_random();
    test_back_to_back();
    test_rr_skip();
    test_reset_mid();
    test_operand_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
